dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns pipeline load/store requests into single-word bus transactions.
// Latency: misaligned requests complete one cycle after accept; aligned ones complete the cycle after bus_ack.
// Backpressure: req_ready is high only while idle; one outstanding request; aborts after TIMEOUT bus cycles.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_sel,
  input  logic [31:0] req_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        done,
  output logic [31:0] ld_data,
  output logic [1:0]  ld_off,
  output logic [2:0]  ld_sel,
  output logic [1:0]  err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Status codes reported alongside done.
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  // Counter value seen during the last permitted BUS cycle.
  localparam logic [7:0] LP_LAST_CNT = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;

  // Captured request context.
  logic        r_we;
  logic [1:0]  r_off;
  logic [2:0]  r_sel;
  logic [1:0]  r_err;
  logic [7:0]  r_cnt;

  // Bus-side registers, held constant through the whole BUS phase.
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;

  // Load-shifter hand-off registers.
  logic [31:0] r_ld_data;
  logic [1:0]  r_ld_off;
  logic [2:0]  r_ld_sel;

  logic        w_accept;
  logic        w_misalign;
  logic        w_expired;
  logic [1:0]  w_a;
  logic [4:0]  w_swl_sh;
  logic [4:0]  w_swr_sh;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_a       = req_addr[1:0];
  assign w_expired = (r_cnt == LP_LAST_CNT);

  // swl shifts right by (3-a) bytes and swr left by a bytes; 3-a on two bits is ~a.
  assign w_swl_sh  = {~w_a, 3'b000};
  assign w_swr_sh  = {w_a, 3'b000};

  // Halfword accesses need an even address, word accesses a word-aligned one; lwl/lwr/swl/swr never fault.
  always_comb begin
    w_misalign = 1'b0;
    case (req_sel)
      3'd2, 3'd3: w_misalign = w_a[0];
      3'd4:       w_misalign = (w_a != 2'b00);
      default:    w_misalign = 1'b0;
    endcase
  end

  // Store lane enables and lane-aligned data; loads drive no enables and zero data.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0000_0000;
    if (req_we) begin
      case (req_sel)
        3'd0, 3'd1: begin
          w_be    = 4'b0001 << w_a;
          w_wdata = {4{req_wdata[7:0]}};
        end
        3'd2, 3'd3: begin
          w_be    = w_a[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{req_wdata[15:0]}};
        end
        3'd4: begin
          w_be    = 4'b1111;
          w_wdata = req_wdata;
        end
        3'd5: begin
          case (w_a)
            2'd0:    w_be = 4'b0001;
            2'd1:    w_be = 4'b0011;
            2'd2:    w_be = 4'b0111;
            default: w_be = 4'b1111;
          endcase
          w_wdata = req_wdata >> w_swl_sh;
        end
        default: begin
          w_be    = 4'b1111 << w_a;
          w_wdata = req_wdata << w_swr_sh;
        end
      endcase
    end
  end

  // State register; reset drops out of BUS at once so bus_req falls asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: ack wins over an expiring counter in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_misalign ? S_RESP : S_BUS;
        end
      end
      S_BUS: begin
        if (bus_ack || w_expired) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, cycle counting and completion status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_off       <= 2'b00;
      r_sel       <= 3'd0;
      r_err       <= ERR_OK;
      r_cnt       <= 8'd0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0000_0000;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we  <= req_we;
            r_off <= w_a;
            r_sel <= req_sel;
            r_cnt <= 8'd0;
            if (w_misalign) begin
              // Bus registers are left alone: no transaction will be issued.
              r_err <= ERR_MISALIGN;
            end else begin
              r_err       <= ERR_OK;
              r_bus_we    <= req_we;
              r_bus_addr  <= {req_addr[31:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_wdata;
            end
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            r_err <= ERR_OK;
          end else if (w_expired) begin
            r_err <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Load results move to the shifter only on an acknowledged load, so they stay put across stores and faults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_data <= 32'h0000_0000;
      r_ld_off  <= 2'b00;
      r_ld_sel  <= 3'd0;
    end else if ((r_state == S_BUS) && bus_ack && !r_we) begin
      r_ld_data <= bus_rdata;
      r_ld_off  <= r_off;
      r_ld_sel  <= r_sel;
    end
  end

  assign bus_req   = (r_state == S_BUS);
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

  assign done      = (r_state == S_RESP);
  assign err       = (r_state == S_RESP) ? r_err : ERR_OK;

  assign ld_data   = r_ld_data;
  assign ld_off    = r_ld_off;
  assign ld_sel    = r_ld_sel;

endmodule

// File: tb/tb_dmem_ctrl.sv
`timescale 1ns/1ps
// Bench for dmem_ctrl built with a short timeout so the abort path is quick to reach.
// Table of load/store vectors plus hand-written idle-ack and mid-transaction reset sequences.
// Expected completions go into a scoreboard queue at drive time and are popped on done.
module tb_dmem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [2:0]  req_sel = 3'd0;
  logic [31:0] req_wdata = 32'h0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        done;
  logic [31:0] ld_data;
  logic [1:0]  ld_off;
  logic [2:0]  ld_sel;
  logic [1:0]  err;

  int errors = 0;
  int checks = 0;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_sel(req_sel), .req_wdata(req_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .done(done), .ld_data(ld_data), .ld_off(ld_off), .ld_sel(ld_sel), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  sel;
    logic [31:0] wdata;
    int          ack_at;   // 1-based BUS cycle carrying bus_ack; 0 = never
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [1:0]  err;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  err;
    int          nbus;
    int          lat;
  } exp_t;

  vec_t vecs[15];
  exp_t sb_q[$];

  // Reference copy of what the load shifter should be holding.
  logic [31:0] m_ld_data = 32'h0;
  logic [1:0]  m_ld_off = 2'b0;
  logic [2:0]  m_ld_sel = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [2:0] sel,
                              input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata,
                              input logic [3:0] be, input logic [31:0] bwdata, input logic [1:0] e);
    vec_t v;
    v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata; v.ack_at = ack_at;
    v.rdata = rdata; v.be = be; v.bwdata = bwdata; v.err = e;
    return v;
  endfunction

  // Drive one request from a negedge and follow it to its done pulse.
  task automatic do_op(input vec_t v);
    exp_t e;
    exp_t g;
    int   cyc;
    int   nb;
    bit   got;
    e.we    = v.we;
    e.addr  = {v.addr[31:2], 2'b00};
    e.be    = v.we ? v.be : 4'b0000;
    e.wdata = v.bwdata;
    e.err   = v.err;
    e.nbus  = (v.err == 2'b01) ? 0 : ((v.ack_at > 0) ? v.ack_at : TO);
    e.lat   = (v.err == 2'b01) ? 1 : e.nbus + 1;
    chk("req_ready idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_sel = v.sel; req_wdata = v.wdata;
    sb_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_sel = 3'($urandom); req_we = 1'($urandom);
    cyc = 0; nb = 0; got = 1'b0;
    g = e;
    while (!got && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (bus_req) begin
        nb++;
        chk("bus_we", 32'(bus_we), 32'(e.we));
        chk("bus_addr", bus_addr, e.addr);
        chk("bus_be", 32'(bus_be), 32'(e.be));
        if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
        if (nb == v.ack_at) begin
          bus_ack = 1'b1; bus_rdata = v.rdata;
        end else begin
          bus_ack = 1'b0; bus_rdata = $urandom;
        end
      end else begin
        bus_ack = 1'b0; bus_rdata = $urandom;
      end
      if (done) begin
        got = 1'b1;
        g = sb_q.pop_front();
        chk("err at done", 32'(err), 32'(g.err));
        chk("done latency", cyc, g.lat);
        chk("bus cycles", nb, g.nbus);
        if (!g.we && g.err == 2'b00) begin
          m_ld_data = v.rdata; m_ld_off = v.addr[1:0]; m_ld_sel = v.sel;
        end
        chk("ld_data", ld_data, m_ld_data);
        chk("ld_off", 32'(ld_off), 32'(m_ld_off));
        chk("ld_sel", 32'(ld_sel), 32'(m_ld_sel));
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done timeout: no done within %0d cycles", cyc);
      sb_q.delete();
    end
    @(negedge clk);
    chk("done one cycle", 32'(done), 32'd0);
    chk("err idle", 32'(err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            we    addr          sel   wdata         ack  rdata         be       bwdata        err
    vecs[0]  = mk(1'b0, 32'h0000_1003, 3'd0, 32'h0,        1, 32'h80FF_1234, 4'b0000, 32'h0,        2'b00); // lb
    vecs[1]  = mk(1'b1, 32'h0000_0002, 3'd0, 32'hAABBCCDD, 1, 32'h0,        4'b0100, 32'hDDDDDDDD, 2'b00); // sb
    vecs[2]  = mk(1'b1, 32'h0000_0001, 3'd5, 32'hAABBCCDD, 1, 32'h0,        4'b0011, 32'h0000AABB, 2'b00); // swl
    vecs[3]  = mk(1'b1, 32'h0000_0001, 3'd6, 32'hAABBCCDD, 1, 32'h0,        4'b1110, 32'hBBCCDD00, 2'b00); // swr
    vecs[4]  = mk(1'b1, 32'h0000_0006, 3'd3, 32'hAABBCCDD, 2, 32'h0,        4'b1100, 32'hCCDDCCDD, 2'b00); // sh hi
    vecs[5]  = mk(1'b1, 32'h0000_0008, 3'd4, 32'hAABBCCDD, 3, 32'h0,        4'b1111, 32'hAABBCCDD, 2'b00); // sw
    vecs[6]  = mk(1'b0, 32'h0000_1002, 3'd4, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        2'b01); // lw misaligned
    vecs[7]  = mk(1'b1, 32'h0000_0005, 3'd2, 32'hAABBCCDD, 1, 32'h0,        4'b0000, 32'h0,        2'b01); // sh misaligned
    vecs[8]  = mk(1'b0, 32'h0000_2002, 3'd3, 32'h0,        2, 32'h12345678, 4'b0000, 32'h0,        2'b00); // lhu
    vecs[9]  = mk(1'b0, 32'h0000_3000, 3'd4, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        2'b10); // lw timeout
    vecs[10] = mk(1'b1, 32'h0000_0040, 3'd4, 32'h11223344, 4, 32'h0,        4'b1111, 32'h11223344, 2'b00); // ack on last cycle
    vecs[11] = mk(1'b1, 32'h0000_0013, 3'd5, 32'hAABBCCDD, 1, 32'h0,        4'b1111, 32'hAABBCCDD, 2'b00); // swl a=3
    vecs[12] = mk(1'b1, 32'h0000_0013, 3'd7, 32'hAABBCCDD, 1, 32'h0,        4'b1000, 32'hDD000000, 2'b00); // swr a=3
    vecs[13] = mk(1'b1, 32'h0000_0021, 3'd1, 32'h00000057, 1, 32'h0,        4'b0010, 32'h57575757, 2'b00); // sb a=1
    vecs[14] = mk(1'b0, 32'h0000_0010, 3'd6, 32'h0,        1, 32'hDEADBEEF, 4'b0000, 32'h0,        2'b00); // lwr

    // Reset values while reset is held.
    #2;
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_we", 32'(bus_we), 32'd0);
    chk("rst bus_be", 32'(bus_be), 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst ld_data", ld_data, 32'd0);
    chk("rst ld_off", 32'(ld_off), 32'd0);
    chk("rst ld_sel", 32'(ld_sel), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after reset", 32'(req_ready), 32'd1);

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i]);
    end

    // bus_ack while idle must not produce a completion or a bus cycle.
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
    repeat (3) begin
      @(negedge clk);
      chk("idle ack no done", 32'(done), 32'd0);
      chk("idle ack no bus_req", 32'(bus_req), 32'd0);
      chk("idle ack ld_data", ld_data, m_ld_data);
    end
    bus_ack = 1'b0;

    // Reset in the middle of a bus transaction.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0500; req_sel = 3'd4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid bus_req c1", 32'(bus_req), 32'd1);
    @(negedge clk);
    chk("mid bus_req c2", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async bus_req drop", 32'(bus_req), 32'd0);
    chk("reset no done", 32'(done), 32'd0);
    m_ld_data = 32'h0; m_ld_off = 2'b0; m_ld_sel = 3'd0;
    repeat (3) begin
      @(negedge clk);
      chk("held reset no done", 32'(done), 32'd0);
      chk("held reset ld_data", ld_data, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset no done", 32'(done), 32'd0);
    do_op(vecs[0]);
    do_op(vecs[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
